// File: rtl/clock_cache_pkg.sv
// Shared types and helpers for the CLOCK-replacement line cache.
package clock_cache_pkg;

  localparam int CC_ADDR_WIDTH = 8;
  localparam int CC_LINE_WIDTH = 32;
  localparam int CC_WAYS       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SWEEP  = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int hand_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic                     refb;
    logic [CC_ADDR_WIDTH-1:0] addr;
    logic [CC_LINE_WIDTH-1:0] data;
  } way_t;

endpackage

// File: rtl/clock_cache_match.sv
// Combinational tag match and lowest-invalid-way search across all ways.
module clock_cache_match #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAYS       = 4,
  parameter int IDX_W      = 2
) (
  input  logic [WAYS-1:0]                 i_valid,
  input  logic [WAYS-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0]           i_key,
  output logic [WAYS-1:0]                 o_hit_vec,
  output logic [IDX_W-1:0]                o_hit_idx,
  output logic                            o_any_inv,
  output logic [IDX_W-1:0]                o_inv_idx
);

  always_comb begin
    o_hit_vec = '0;
    o_hit_idx = '0;
    o_any_inv = 1'b0;
    o_inv_idx = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (i_valid[i] && (i_addr[i] == i_key)) begin
        o_hit_vec[i] = 1'b1;
        o_hit_idx    = IDX_W'(i);
      end
      if (!i_valid[i] && !o_any_inv) begin
        o_any_inv = 1'b1;
        o_inv_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/clock_cache.sv
// Fully associative cache with CLOCK (second-chance) replacement.
// Optional saturating statistics counters under CLOCK_CACHE_STATS_EN.
module clock_cache
  import clock_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CC_ADDR_WIDTH,
  parameter int LINE_WIDTH = CC_LINE_WIDTH,
  parameter int WAYS       = CC_WAYS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  evict_valid,
  output logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [LINE_WIDTH-1:0] evict_data
`ifdef CLOCK_CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_evictions
`endif
);

  localparam int HW = hand_width(WAYS);

  state_t r_state, w_next;

  logic [WAYS-1:0]                 r_valid, r_refb;
  logic [WAYS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [WAYS-1:0][LINE_WIDTH-1:0] r_data;
  logic [HW-1:0]                   r_hand;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_laddr;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic                  r_resp_valid, r_resp_hit, r_evict_valid;
  logic [LINE_WIDTH-1:0] r_resp_rdata, r_evict_data;
  logic [ADDR_WIDTH-1:0] r_evict_addr;

  logic [WAYS-1:0] w_hit_vec;
  logic [HW-1:0]   w_hit_idx, w_inv_idx;
  logic            w_any_inv, w_hit;

  clock_cache_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAYS       (WAYS),
    .IDX_W      (HW)
  ) u_match (
    .i_valid   (r_valid),
    .i_addr    (r_addr),
    .i_key     (r_laddr),
    .o_hit_vec (w_hit_vec),
    .o_hit_idx (w_hit_idx),
    .o_any_inv (w_any_inv),
    .o_inv_idx (w_inv_idx)
  );

  assign w_hit = |w_hit_vec;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = LOOKUP;
      LOOKUP:  w_next = (w_hit || !r_write || w_any_inv) ? RESP : SWEEP;
      SWEEP:   if (!r_refb[r_hand]) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Response fields default to zero every cycle, so they are high only in RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= '0;
      r_refb        <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_hand        <= '0;
      r_write       <= 1'b0;
      r_laddr       <= '0;
      r_wdata       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_rdata  <= '0;
      r_evict_valid <= 1'b0;
      r_evict_addr  <= '0;
      r_evict_data  <= '0;
    end else begin
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_rdata  <= '0;
      r_evict_valid <= 1'b0;
      r_evict_addr  <= '0;
      r_evict_data  <= '0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_laddr <= req_addr;
            r_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_refb[w_hit_idx] <= 1'b1;
            r_resp_hit        <= 1'b1;
            r_resp_valid      <= 1'b1;
            if (r_write) r_data[w_hit_idx] <= r_wdata;
            else         r_resp_rdata      <= r_data[w_hit_idx];
          end else if (!r_write) begin
            r_resp_valid <= 1'b1;
          end else if (w_any_inv) begin
            r_valid[w_inv_idx] <= 1'b1;
            r_refb[w_inv_idx]  <= 1'b1;
            r_addr[w_inv_idx]  <= r_laddr;
            r_data[w_inv_idx]  <= r_wdata;
            r_resp_valid       <= 1'b1;
          end
        end
        SWEEP: begin
          r_hand <= r_hand + 1'b1;
          if (r_refb[r_hand]) begin
            r_refb[r_hand] <= 1'b0;
          end else begin
            r_evict_valid  <= 1'b1;
            r_evict_addr   <= r_addr[r_hand];
            r_evict_data   <= r_data[r_hand];
            r_addr[r_hand] <= r_laddr;
            r_data[r_hand] <= r_wdata;
            r_refb[r_hand] <= 1'b1;
            r_resp_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = reset_n && (r_state == IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_rdata  = r_resp_rdata;
  assign evict_valid = r_evict_valid;
  assign evict_addr  = r_evict_addr;
  assign evict_data  = r_evict_data;

`ifdef CLOCK_CACHE_STATS_EN
  logic [31:0] r_hits, r_misses, r_evicts;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_evicts <= '0;
    end else if (r_state == RESP) begin
      if (r_resp_hit) begin
        if (r_hits != '1) r_hits <= r_hits + 1'b1;
      end else begin
        if (r_misses != '1) r_misses <= r_misses + 1'b1;
      end
      if (r_evict_valid && (r_evicts != '1)) r_evicts <= r_evicts + 1'b1;
    end
  end

  assign stat_hits      = r_hits;
  assign stat_misses    = r_misses;
  assign stat_evictions = r_evicts;
`endif

endmodule

// File: tb/tb_clock_cache.sv
// Directed scoreboard bench for clock_cache; stats checked when CLOCK_CACHE_STATS_EN is defined.
module tb_clock_cache;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_hit, evict_valid;
  logic [31:0] resp_rdata, evict_data;
  logic [7:0]  evict_addr;
`ifdef CLOCK_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_evictions;
`endif

  always #5 clock = ~clock;

  clock_cache #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .WAYS(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_rdata  (resp_rdata),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data)
`ifdef CLOCK_CACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses),
    .stat_evictions (stat_evictions)
`endif
  );

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
    logic        ev;
    logic [7:0]  ea;
    logic [31:0] ed;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int exp_hits = 0, exp_misses = 0, exp_evicts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_outs", {28'd0, resp_valid, resp_hit, evict_valid, |{resp_rdata, evict_addr, evict_data}}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_hits = 0; exp_misses = 0; exp_evicts = 0;
    @(negedge clock);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Accept a request and leave the bench at the first negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
    int w;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clock); w++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    @(negedge clock);
  endtask

  task automatic req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input logic hit, input logic [31:0] rd, input logic ev,
                     input logic [7:0] ea, input logic [31:0] ed, input int lat);
    exp_t e;
    int l;
    sb.push_back('{hit, rd, ev, ea, ed, lat});
    issue(wr, a, d);
    l = 1;
    while (!resp_valid && l < 20) begin @(negedge clock); l++; end
    check("resp_seen", {31'd0, resp_valid}, 32'd1);
    e = sb.pop_front();
    check("latency", l, e.lat);
    check("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
    check("resp_rdata", resp_rdata, e.rdata);
    check("evict_valid", {31'd0, evict_valid}, {31'd0, e.ev});
    check("evict_addr", {24'd0, evict_addr}, {24'd0, e.ea});
    check("evict_data", evict_data, e.ed);
    if (e.hit) exp_hits++; else exp_misses++;
    if (e.ev) exp_evicts++;
    @(negedge clock);
    check("resp_pulse", {30'd0, resp_valid, evict_valid}, 32'd0);
  endtask

  task automatic check_stats();
`ifdef CLOCK_CACHE_STATS_EN
    check("stat_hits", stat_hits, exp_hits);
    check("stat_misses", stat_misses, exp_misses);
    check("stat_evictions", stat_evictions, exp_evicts);
`endif
  endtask

  initial begin
    int q;
    do_reset();
    // Read miss on empty cache, fill, then read hit.
    req(1'b0, 8'h10, 32'h0,        1'b0, 32'h0,        1'b0, 8'h00, 32'h0, 2);
    req(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 8'h00, 32'h0, 2);
    req(1'b0, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0, 2);
    check_stats();

    do_reset();
    req(1'b0, 8'h10, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 2);
    for (int i = 1; i <= 4; i++)
      req(1'b1, 8'(i), 32'h100 + i, 1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 2);
    // All refs set: full rotation (5 sweep cycles), way 0 evicted.
    req(1'b1, 8'h05, 32'h105, 1'b0, 32'h0,   1'b1, 8'h01, 32'h101, 7);
    req(1'b0, 8'h02, 32'h0,   1'b1, 32'h102, 1'b0, 8'h00, 32'h0,   2);
    // Hand at 1: way 1 gets second chance, way 2 evicted.
    req(1'b1, 8'h06, 32'h106, 1'b0, 32'h0,   1'b1, 8'h03, 32'h103, 4);
    req(1'b1, 8'h05, 32'hCAFE0005, 1'b1, 32'h0, 1'b0, 8'h00, 32'h0, 2);
    req(1'b0, 8'h05, 32'h0, 1'b1, 32'hCAFE0005, 1'b0, 8'h00, 32'h0, 2);
    req(1'b0, 8'h77, 32'h0, 1'b0, 32'h0,        1'b0, 8'h00, 32'h0, 2);
    // Hand at 3 with ref clear: single sweep cycle.
    req(1'b1, 8'h07, 32'h107, 1'b0, 32'h0, 1'b1, 8'h04, 32'h104, 3);
    req(1'b0, 8'h06, 32'h0,   1'b1, 32'h106, 1'b0, 8'h00, 32'h0, 2);
    check_stats();

    // Evicting write abandoned by reset while in SWEEP.
    issue(1'b1, 8'h08, 32'h108);
    @(negedge clock);
    reset_n = 1'b0;
    q = 0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) q++;
    end
    check("no_resp_in_reset", q, 0);
    check("ready_in_reset", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b1;
    exp_hits = 0; exp_misses = 0; exp_evicts = 0;
    q = 0;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid) q++;
    end
    check("no_resp_after_reset", q, 0);
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    req(1'b0, 8'h02, 32'h0,   1'b0, 32'h0,   1'b0, 8'h00, 32'h0, 2);
    req(1'b1, 8'h02, 32'h202, 1'b0, 32'h0,   1'b0, 8'h00, 32'h0, 2);
    req(1'b0, 8'h02, 32'h0,   1'b1, 32'h202, 1'b0, 8'h00, 32'h0, 2);
    check_stats();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_cache.md
Name: clock_cache

Overview:
Parametrised fully associative cache with CLOCK (second-chance) replacement, valid bits, a ready/valid request handshake, and eviction reporting. It is the next generation of our K-way line cache:
- K is now an arbitrary power of two.
- The block has reset.
- Invalid ways are filled before any eviction.
- Every request gets a single-cycle registered response.

It sits between a requester (core/test driver) and a backing store. The backing store consumes the eviction output.

Parameters:
ADDR_WIDTH, 8, tag/address width in bits.
LINE_WIDTH, 32, data bits per line.
WAYS, 4, number of ways; power of two, >= 2.

Ports:
clock  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  LINE_WIDTH  write data.
resp_valid  output  1  one-cycle response pulse.
resp_hit  output  1  address was resident (reads) / write hit existing line (writes).
resp_rdata  output  LINE_WIDTH  read data; 0 on read miss and on writes.
evict_valid  output  1  valid with resp_valid; a valid line was replaced.
evict_addr  output  ADDR_WIDTH  address of replaced line.
evict_data  output  LINE_WIDTH  data of replaced line.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clock and reset_n.
- State per way: valid, ref, addr, data. Global state: hand of clog2(WAYS) bits, and the FSM.
- Reset (async assert, sync deassert by the surrounding logic):
  - all valid = 0, ref = 0, hand = 0, FSM = IDLE.
  - all outputs 0, except req_ready = 0 while reset_n is low.
- Reset mid-operation: the in-flight request is abandoned and produces no response.
- FSM states: IDLE, LOOKUP, SWEEP, RESP.
- IDLE:
  - req_ready = 1; req_ready is 0 in all other states.
  - On req_valid && req_ready: latch write/addr/wdata; go to LOOKUP.
- LOOKUP: parallel compare of the latched addr against all valid ways. At most one match is possible.
  - Hit, read: rdata = data[w]; ref[w] = 1 -> RESP.
  - Hit, write: data[w] = wdata; ref[w] = 1; resp_hit = 1 -> RESP.
  - Miss, read: no allocation; resp_hit = 0; rdata = 0 -> RESP.
  - Miss, write, some way invalid: fill the lowest-index invalid way (valid = 1, ref = 1); hand unchanged; evict_valid = 0; resp_hit = 0 -> RESP.
  - Miss, write, all ways valid -> SWEEP.
- SWEEP: one way examined per cycle, at hand.
  - ref[hand] = 1: clear it; hand = hand + 1 (wraps mod WAYS).
  - ref[hand] = 0: record the old addr/data as the eviction; overwrite the way (ref = 1); hand = hand + 1; evict_valid = 1; resp_hit = 0 -> RESP.
  - Worst case is WAYS + 1 SWEEP cycles (every ref set).
- RESP:
  - resp_valid = 1 for exactly one cycle, with hit/rdata/evict fields stable that cycle.
  - Next state IDLE; resp_* and evict_* clear to 0 afterwards.
- Latency from the accepting edge to resp_valid high:
  - 2 cycles for hits, read misses, and invalid-fill writes.
  - 2 + n cycles for evicting writes, where n = number of SWEEP cycles (1 to WAYS + 1).
- Throughput: one request in flight; a new request is accepted no earlier than the cycle after resp_valid.
- Requester-side inputs are ignored while req_ready = 0.

Optional Feature:
Macro CLOCK_CACHE_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses, stat_evictions, each 32 bits.
  - Each counter increments in the RESP cycle, based on resp_hit / evict_valid.
  - Counters saturate at all-ones and are cleared by reset_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package clock_cache_pkg holds:
  - the state enum typedef (IDLE, LOOKUP, SWEEP, RESP);
  - the function computing the hand width, clog2(WAYS);
  - a way-state struct typedef parametrised through localparams.
- One sub-module, clock_cache_match. It is purely combinational and produces:
  - a one-hot hit vector and the hit index;
  - an any-invalid flag and the lowest-invalid index.
- The FSM and way storage stay in clock_cache.

Test Plan:
- Reset, then read 0x10 -> resp_valid 2 cycles after accept; resp_hit = 0; rdata = 0; evict_valid = 0.
- Write 0x10 = 0xDEADBEEF, then read 0x10 -> first response hit = 0, evict_valid = 0; second response hit = 1, rdata = 0xDEADBEEF, latency 2.
- WAYS = 4: write 0x01..0x04, then write 0x05 -> SWEEP runs 5 cycles (all refs cleared, hand wraps to 0) and way 0 is evicted. Required response: latency 7, evict_valid = 1, evict_addr = 0x01, hand = 1.
- Continue from the previous scenario: read 0x02 (sets ref), then write 0x06 -> way 1 skipped, way 2 evicted; evict_addr = 0x03.
- Assert reset_n low during SWEEP -> no resp_valid; after release, read of 0x02 misses (all invalid); req_ready = 1.
- With CLOCK_CACHE_STATS_EN: after the sequence above, stat_hits/misses/evictions match the scoreboard exactly.
